clock_time_core: RTL and testbench

//  Timekeeping core of the digital-clock design. Divides the board clock to a 1 Hz tick.

---
 rtl/clock_time_core.sv | 137 +++++++++++++
 tb/tb_clock_time_core.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clock_time_core.sv
// Timekeeping core: divides clk to a 1 Hz tick and keeps 24-hour HH:MM:SS as BCD digits.
// A SET mode freezes time and lets the user step the hour, minute or second field.
module clock_time_core #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       set_mode,
  input  logic [1:0] sel_field,
  input  logic       inc_btn,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       day_wrap
);
  localparam int CW = $clog2(CLK_FREQ);
  localparam logic [CW-1:0] TERM = CW'(CLK_FREQ - 1);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inc_q;
  logic [3:0]    hr_tens_q, hr_ones_q, min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0]    hr_tens_d, hr_ones_d, min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic          sec_tick_q, sec_tick_d, day_wrap_q, day_wrap_d;
  logic          in_set, tick, inc_edge;
  logic          sec_last, min_last, hr_last;

  // One BCD field step: wraps to 00 after {t_max,o_max}, otherwise ones roll into tens.
  function automatic logic [7:0] inc_bcd(input logic [3:0] t, input logic [3:0] o,
                                         input logic [3:0] t_max, input logic [3:0] o_max);
    if (t == t_max && o == o_max) return 8'h00;
    else if (o == 4'd9)           return {t + 4'd1, 4'd0};
    else                          return {t, o + 4'd1};
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next-state logic: set_mode is a plain level selecting the state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: if (set_mode)  state_d = SET;
      SET: if (!set_mode) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State outputs; a terminal count coinciding with entry to SET is dropped
  always_comb begin
    in_set   = (state_q == SET);
    tick     = !in_set && !set_mode && run_en && (cnt_q == TERM);
    inc_edge = in_set && inc_btn && !inc_q;
  end

  assign sec_last = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
  assign min_last = (min_tens_q == 4'd5) && (min_ones_q == 4'd9);
  assign hr_last  = (hr_tens_q  == 4'd2) && (hr_ones_q  == 4'd3);

  always_comb begin
    cnt_d      = cnt_q;
    hr_tens_d  = hr_tens_q;
    hr_ones_d  = hr_ones_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;

    if (in_set)      cnt_d = '0;
    else if (run_en) cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;

    if (tick) begin
      sec_tick_d = 1'b1;
      {sec_tens_d, sec_ones_d} = inc_bcd(sec_tens_q, sec_ones_q, 4'd5, 4'd9);
      if (sec_last)
        {min_tens_d, min_ones_d} = inc_bcd(min_tens_q, min_ones_q, 4'd5, 4'd9);
      if (sec_last && min_last)
        {hr_tens_d, hr_ones_d} = inc_bcd(hr_tens_q, hr_ones_q, 4'd2, 4'd3);
      day_wrap_d = sec_last && min_last && hr_last;
    end else if (inc_edge) begin
      // Field steps wrap inside the field only; no carry into the next one
      case (sel_field)
        2'd0: {sec_tens_d, sec_ones_d} = inc_bcd(sec_tens_q, sec_ones_q, 4'd5, 4'd9);
        2'd1: {min_tens_d, min_ones_d} = inc_bcd(min_tens_q, min_ones_q, 4'd5, 4'd9);
        2'd2: {hr_tens_d, hr_ones_d}   = inc_bcd(hr_tens_q, hr_ones_q, 4'd2, 4'd3);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      inc_q      <= 1'b0;
      hr_tens_q  <= '0;
      hr_ones_q  <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inc_q      <= inc_btn;
      hr_tens_q  <= hr_tens_d;
      hr_ones_q  <= hr_ones_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign hr_tens  = hr_tens_q;
  assign hr_ones  = hr_ones_q;
  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
endmodule

// File: tb/tb_clock_time_core.sv
// Bench for clock_time_core: table vectors, directed corner sequences and a random run
// compared every cycle against a seconds-of-day reference model.
module tb_clock_time_core;
  localparam int CF = 10;

  logic       clk = 1'b0, rst = 1'b1, run_en = 1'b0, set_mode = 1'b0, inc_btn = 1'b0;
  logic [1:0] sel_field = 2'd3;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic       sec_tick, day_wrap;

  clock_time_core #(.CLK_FREQ(CF)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .set_mode(set_mode), .sel_field(sel_field),
    .inc_btn(inc_btn), .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .sec_tick(sec_tick), .day_wrap(day_wrap));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  wire [23:0] digits = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: time as seconds of day, prescaler as a plain phase count
  int m_t = 0, m_cnt = 0;
  bit m_set = 0, m_inc = 0, m_tick = 0, m_wrap = 0;

  always @(posedge clk or posedge rst) begin
    int t, h, m, s;
    bit tk;
    if (rst) begin
      m_t <= 0; m_cnt <= 0; m_set <= 0; m_inc <= 0; m_tick <= 0; m_wrap <= 0;
    end else begin
      tk = !m_set && !set_mode && run_en && (m_cnt == CF - 1);
      t  = tk ? (m_t + 1) % 86400 : m_t;
      if (!tk && m_set && inc_btn && !m_inc) begin
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        case (sel_field)
          2'd0: s = (s + 1) % 60;
          2'd1: m = (m + 1) % 60;
          2'd2: h = (h + 1) % 24;
          default: ;
        endcase
        t = (h * 60 + m) * 60 + s;
      end
      m_t    <= t;
      m_tick <= tk;
      m_wrap <= tk && (m_t == 86399);
      m_cnt  <= m_set ? 0 : (run_en ? (m_cnt + 1) % CF : m_cnt);
      m_set  <= set_mode;
      m_inc  <= inc_btn;
    end
  end

  function automatic logic [25:0] model_vec(input int t, input bit tk, input bit wr);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), tk, wr};
  endfunction

  always @(negedge clk)
    chk("model", {digits, sec_tick, day_wrap}, model_vec(m_t, m_tick, m_wrap));

  task automatic tk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int n);
    repeat (n) begin inc_btn = 1'b1; tk(1); inc_btn = 1'b0; tk(1); end
  endtask

  task automatic do_reset(input logic ren);
    run_en = ren; set_mode = 1'b0; inc_btn = 1'b0; sel_field = 2'd3;
    rst = 1'b1; tk(2); rst = 1'b0;
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    set_mode = 1'b1; tk(1);
    sel_field = 2'd2; pulse(hh);
    sel_field = 2'd1; pulse(mm);
    sel_field = 2'd0; pulse(ss);
    sel_field = 2'd3;
  endtask

  typedef struct {
    bit          sm;
    logic [1:0]  sel;
    int          pulses;
    int          run;
    logic [23:0] exp;
  } vec_t;
  vec_t vt[10];

  initial begin
    int n, w;
    vt[0] = '{1, 2'd2, 25,  0,   24'h010000};
    vt[1] = '{1, 2'd1, 59,  0,   24'h015900};
    vt[2] = '{1, 2'd1, 1,   0,   24'h010000};
    vt[3] = '{1, 2'd0, 61,  0,   24'h010001};
    vt[4] = '{1, 2'd3, 5,   0,   24'h010001};
    vt[5] = '{1, 2'd2, 8,   0,   24'h090001};
    vt[6] = '{1, 2'd2, 1,   0,   24'h100001};
    vt[7] = '{0, 2'd3, 0,   10,  24'h100002};
    vt[8] = '{0, 2'd3, 0,   590, 24'h100101};
    vt[9] = '{1, 2'd0, 0,   0,   24'h100101};

    #1 chk("reset_state", {digits, sec_tick, day_wrap}, 26'd0);
    tk(2); rst = 1'b0;

    // Free run: first second, then a full minute
    run_en = 1'b1; n = 0;
    repeat (10) begin tk(1); n += int'(sec_tick); end
    chk("first_sec_ticks", n, 1);
    chk("first_sec_time", digits, 24'h000001);
    tk(590);
    chk("one_minute", digits, 24'h000100);

    // Table of SET steps and run stretches
    do_reset(1'b0);
    foreach (vt[i]) begin
      set_mode = vt[i].sm; sel_field = vt[i].sel; tk(1);
      pulse(vt[i].pulses);
      if (vt[i].run > 0) begin set_mode = 1'b0; run_en = 1'b1; tk(vt[i].run); end
      chk($sformatf("vec%0d", i), digits, vt[i].exp);
    end

    // Day wrap from 23:59:58
    do_reset(1'b1);
    set_time(23, 59, 58);
    chk("preload", digits, 24'h235958);
    set_mode = 1'b0; w = 0;
    repeat (21) begin tk(1); w += int'(day_wrap); end
    chk("wrap_time", digits, 24'h000000);
    chk("wrap_pulses", w, 1);

    // Held button gives one step; sel 3 does nothing; edge seen in RUN is ignored
    set_mode = 1'b1; sel_field = 2'd0; tk(1);
    inc_btn = 1'b1; tk(50); inc_btn = 1'b0; tk(1);
    chk("held_inc", digits, 24'h000001);
    sel_field = 2'd3; pulse(5);
    chk("sel_none", digits, 24'h000001);
    set_mode = 1'b0; run_en = 1'b0; sel_field = 2'd0; tk(1);
    inc_btn = 1'b1; tk(1); set_mode = 1'b1; tk(3); inc_btn = 1'b0; tk(1);
    chk("run_edge_ignored", digits, 24'h000001);

    // set_mode rising on the terminal count discards that tick
    do_reset(1'b1);
    n = 0;
    while (m_cnt != CF - 1 && n < 20) begin tk(1); n++; end
    chk("tc_reached", m_cnt, CF - 1);
    set_mode = 1'b1; tk(1);
    chk("tc_discard_time", digits, 24'h000000);
    chk("tc_discard_tick", sec_tick, 1'b0);
    set_mode = 1'b0; n = 0;
    while (n < 30) begin tk(1); n++; if (sec_tick) break; end
    chk("set_exit_latency", n, 11);
    chk("set_exit_time", digits, 24'h000001);

    // Async reset mid-second, then prescaler hold with run_en=0
    do_reset(1'b0);
    set_time(12, 34, 56);
    set_mode = 1'b0; run_en = 1'b1; tk(5);
    chk("pre_rst_time", digits, 24'h123456);
    #3 rst = 1'b1;
    #1 chk("async_rst", {digits, sec_tick}, 25'd0);
    tk(1); rst = 1'b0;
    run_en = 1'b0; tk(30);
    chk("hold_idle", digits, 24'h000000);
    run_en = 1'b1; tk(5); run_en = 1'b0; tk(30); run_en = 1'b1; tk(4);
    chk("hold_mid", digits, 24'h000000);
    tk(1);
    chk("hold_resume", digits, 24'h000001);

    // Random traffic checked cycle by cycle against the model
    do_reset(1'b1);
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
      run_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) inc_btn = ~inc_btn;
      sel_field = 2'($urandom_range(0, 3));
      tk(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
